// File: rtl/herald_op_sequencer_if.sv
// ----------------------------------------------------------------------------
// herald_op_sequencer_if
//   Byte-stream bundle between a host and herald_op_sequencer.
//   in_*  : command bytes, host -> sequencer (valid/ready)
//   out_* : response bytes, sequencer -> host (valid/ready)
//   master modport = host side, slave modport = sequencer side.
// ----------------------------------------------------------------------------
interface herald_op_sequencer_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );
endinterface

// File: rtl/herald_op_sequencer.sv
// ----------------------------------------------------------------------------
// herald_op_sequencer
//   Decodes a command byte stream, collects operands, fires one of two
//   attached engines (MAC or CORDIC), waits for its done, and streams the
//   result back MSB first.
//
//   Opcodes: 0x01 MAC    (a_hi a_lo b_hi b_lo)    -> acc[31:0], 4 bytes
//            0x02 CLR    (no operands)            -> 0xA5, clears err
//            0x03 CORDIC (angle_hi angle_lo)      -> cos, sin, 4 bytes
//            other       sets err                 -> 0xEE
//
//   Ports
//     clk, rst_n        clock, async active-low reset
//     ena               global enable; low freezes all state and handshakes
//     bus (slave)       in_data/in_valid/in_ready, out_data/out_valid/out_ready
//     mac_*             MAC engine: start/clr pulses, a/b operands, done/acc
//     cor_*             CORDIC engine: start pulse, angle, done/cos/sin
//     busy              FSM not in IDLE
//     err               sticky error (unknown opcode or timeout), cleared by CLR
//
//   Build option
//     HERALD_SEQ_TIMEOUT_EN  adds an 8-bit WAIT watchdog; after TIMEOUT_CYCLES
//                            cycles without done the command ends with 0xEE
//                            and err set. Undefined: WAIT waits forever.
// ----------------------------------------------------------------------------
module herald_op_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        ena,
  herald_op_sequencer_if.slave        bus,
  // MAC engine
  output logic                        mac_start,
  output logic                        mac_clr,
  output logic [15:0]                 mac_a,
  output logic [15:0]                 mac_b,
  input  logic                        mac_done,
  input  logic [31:0]                 mac_acc,
  // CORDIC engine
  output logic                        cor_start,
  output logic [15:0]                 cor_angle,
  input  logic                        cor_done,
  input  logic [15:0]                 cor_cos,
  input  logic [15:0]                 cor_sin,
  // status
  output logic                        busy,
  output logic                        err
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_OPERAND = 3'd1;
  localparam logic [2:0] S_ISSUE   = 3'd2;
  localparam logic [2:0] S_WAIT    = 3'd3;
  localparam logic [2:0] S_RESP    = 3'd4;

  localparam logic [1:0] OP_MAC = 2'd0;
  localparam logic [1:0] OP_CLR = 2'd1;
  localparam logic [1:0] OP_COR = 2'd2;

  localparam logic [7:0] BYTE_ERR = 8'hEE;
  localparam logic [7:0] BYTE_CLR = 8'hA5;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [2:0]  state, state_nxt;
  logic [1:0]  op;
  logic [2:0]  opnd_left;   // operand bytes still expected
  logic [2:0]  resp_left;   // response bytes still to send
  logic [31:0] resp_sr;     // response shift register, top byte on out_data
  logic        in_ready_q;
  logic        out_valid_q;
  logic        in_fire;
  logic        out_fire;
  logic        done_hit;
  logic        timeout_hit;

  assign in_fire  = ena && bus.in_valid && in_ready_q;
  assign out_fire = ena && out_valid_q && bus.out_ready;

  // Only the engine that was started may end WAIT.
  assign done_hit = ((op == OP_MAC) && mac_done) || ((op == OP_COR) && cor_done);

`ifdef HERALD_SEQ_TIMEOUT_EN
  logic [7:0] to_cnt;

  // Counts cycles spent in WAIT; zero everywhere else.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt <= '0;
    end else if (ena) begin
      if (state == S_WAIT) to_cnt <= to_cnt + 8'd1;
      else                 to_cnt <= '0;
    end
  end

  // Fires on the TIMEOUT_CYCLES-th WAIT cycle; a done in that same cycle wins.
  assign timeout_hit = (state == S_WAIT) && !done_hit && (to_cnt == TO_LAST);
`else
  // Watchdog compiled out; the term below is constant zero and only keeps
  // the parameter referenced in this build.
  assign timeout_hit = 1'b0 & (TO_LAST == 8'd0);
`endif

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    if (ena) begin
      case (state)
        S_IDLE: begin
          if (in_fire) begin
            case (bus.in_data)
              8'h01, 8'h03: state_nxt = S_OPERAND;
              8'h02:        state_nxt = S_ISSUE;
              default:      state_nxt = S_RESP;
            endcase
          end
        end
        S_OPERAND: if (in_fire && opnd_left == 3'd1) state_nxt = S_ISSUE;
        S_ISSUE:   state_nxt = (op == OP_CLR) ? S_RESP : S_WAIT;
        S_WAIT:    if (done_hit || timeout_hit) state_nxt = S_RESP;
        S_RESP:    if (out_fire && resp_left == 3'd1) state_nxt = S_IDLE;
        default:   state_nxt = S_IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // State and datapath
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      op          <= OP_MAC;
      opnd_left   <= '0;
      resp_left   <= '0;
      resp_sr     <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      mac_a       <= '0;
      mac_b       <= '0;
      cor_angle   <= '0;
      err         <= 1'b0;
    end else if (ena) begin
      state <= state_nxt;
      // Registered ready: open only while the next state accepts bytes,
      // which also keeps it low during reset.
      in_ready_q <= (state_nxt == S_IDLE) || (state_nxt == S_OPERAND);

      case (state)
        S_IDLE: begin
          if (in_fire) begin
            case (bus.in_data)
              8'h01: begin
                op        <= OP_MAC;
                opnd_left <= 3'd4;
              end
              8'h02: begin
                op  <= OP_CLR;
                err <= 1'b0;
              end
              8'h03: begin
                op        <= OP_COR;
                opnd_left <= 3'd2;
              end
              default: begin
                err       <= 1'b1;
                resp_sr   <= {BYTE_ERR, 24'h0};
                resp_left <= 3'd1;
              end
            endcase
          end
        end

        S_OPERAND: begin
          if (in_fire) begin
            opnd_left <= opnd_left - 3'd1;
            // Operands shift in MSB first straight into the engine registers;
            // they are complete and frozen by the time ISSUE is reached.
            if (op == OP_MAC) {mac_a, mac_b} <= {mac_a[7:0], mac_b, bus.in_data};
            else              cor_angle      <= {cor_angle[7:0], bus.in_data};
          end
        end

        S_ISSUE: begin
          if (op == OP_CLR) begin
            resp_sr   <= {BYTE_CLR, 24'h0};
            resp_left <= 3'd1;
          end
        end

        S_WAIT: begin
          if (done_hit) begin
            resp_sr   <= (op == OP_MAC) ? mac_acc : {cor_cos, cor_sin};
            resp_left <= 3'd4;
          end else if (timeout_hit) begin
            err       <= 1'b1;
            resp_sr   <= {BYTE_ERR, 24'h0};
            resp_left <= 3'd1;
          end
        end

        S_RESP: begin
          // First RESP cycle only raises valid; afterwards each accepted byte
          // shifts the next one up and the last one drops valid.
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
          end else if (out_fire) begin
            resp_sr   <= {resp_sr[23:0], 8'h00};
            resp_left <= resp_left - 3'd1;
            if (resp_left == 3'd1) out_valid_q <= 1'b0;
          end
        end

        default: ;
      endcase
    end
  end

  // Start/clear pulses are gated by ena so a frozen ISSUE state does not
  // repeat them; the pulse fires on the single enabled ISSUE cycle.
  assign mac_start = ena && (state == S_ISSUE) && (op == OP_MAC);
  assign mac_clr   = ena && (state == S_ISSUE) && (op == OP_CLR);
  assign cor_start = ena && (state == S_ISSUE) && (op == OP_COR);

  assign busy          = (state != S_IDLE);
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = resp_sr[31:24];

endmodule

// File: tb/tb_herald_op_sequencer.sv
module tb_herald_op_sequencer;
  logic        clk;
  logic        rst_n;
  logic        ena;
  logic        mac_start, mac_clr, cor_start;
  logic [15:0] mac_a, mac_b, cor_angle;
  logic        mac_done, cor_done;
  logic [31:0] mac_acc;
  logic [15:0] cor_cos, cor_sin;
  logic        busy, err;

  herald_op_sequencer_if bus();

  herald_op_sequencer #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .bus(bus),
    .mac_start(mac_start), .mac_clr(mac_clr), .mac_a(mac_a), .mac_b(mac_b),
    .mac_done(mac_done), .mac_acc(mac_acc),
    .cor_start(cor_start), .cor_angle(cor_angle), .cor_done(cor_done),
    .cor_cos(cor_cos), .cor_sin(cor_sin),
    .busy(busy), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Engine models: MAC answers 1 cycle after start (when enabled); CORDIC
  // answers 1 or 3 cycles after start. spur_en makes mac_done pulse after a
  // CORDIC start, which the sequencer has to ignore.
  logic       mac_en, spur_en, cor_slow;
  logic [2:0] cor_pipe;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mac_done <= 1'b0;
      cor_pipe <= 3'b000;
    end else begin
      mac_done <= (mac_start && mac_en) || (cor_start && spur_en);
      cor_pipe <= {cor_pipe[1:0], cor_start};
    end
  end
  assign cor_done = cor_slow ? cor_pipe[2] : cor_pipe[0];

  int cyc = 0, mac_start_cnt = 0, mac_clr_cnt = 0, cor_start_cnt = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mac_start) mac_start_cnt <= mac_start_cnt + 1;
    if (mac_clr)   mac_clr_cnt   <= mac_clr_cnt + 1;
    if (cor_start) cor_start_cnt <= cor_start_cnt + 1;
  end

  int passed = 0, failed = 0, total = 0;
  int t0, t_valid, n_mac, n_clr, n_cor;
  logic [7:0] b;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the byte transferred.
  // in_valid is left high so consecutive calls stream back to back.
  task automatic send_byte(input logic [7:0] d);
    int k = 0;
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k >= 100) chk("send_timeout", 32'(k), 32'd0);
    @(negedge clk);
  endtask

  task automatic wait_valid();
    int k = 0;
    while (!bus.out_valid && k < 400) begin
      @(negedge clk);
      k++;
    end
    if (k >= 400) chk("valid_timeout", 32'(k), 32'd0);
    t_valid = cyc;
  endtask

  task automatic recv_byte(output logic [7:0] d);
    bus.out_ready = 1'b1;
    wait_valid();
    d = bus.out_data;
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b1; ena = 1'b1;
    bus.in_data = 8'h00; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    mac_en = 1'b1; spur_en = 1'b0; cor_slow = 1'b0;
    mac_acc = 32'h0; cor_cos = 16'h0; cor_sin = 16'h0;

    // ---- reset values
    #2 rst_n = 1'b0;
    #1;
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 8'h00);
    chk("rst_busy_err", {busy, err}, 0);
    chk("rst_starts", {mac_start, mac_clr, cor_start}, 0);
    chk("rst_operands", {mac_a, mac_b}, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // ---- MAC 01 00 03 00 04 -> 00 00 00 0C, minimum latency 4+3
    mac_acc = 32'h0000000C;
    send_byte(8'h01); t0 = cyc;
    send_byte(8'h00); send_byte(8'h03); send_byte(8'h00); send_byte(8'h04);
    bus.in_valid = 1'b0;
    wait_valid();
    chk("mac_latency", 32'(t_valid - t0), 32'd7);
    chk("mac_a", mac_a, 16'h0003);
    chk("mac_b", mac_b, 16'h0004);
    chk("mac_in_ready_resp", bus.in_ready, 0);
    recv_byte(b); chk("mac_b0", b, 8'h00);
    recv_byte(b); chk("mac_b1", b, 8'h00);
    recv_byte(b); chk("mac_b2", b, 8'h00);
    recv_byte(b); chk("mac_b3", b, 8'h0C);
    chk("mac_start_cnt", 32'(mac_start_cnt), 32'd1);
    chk("mac_idle", {busy, bus.out_valid}, 0);

    // ---- CORDIC 03 20 00 -> 3B 21 18 7E, with a stray mac_done in WAIT
    cor_cos = 16'h3B21; cor_sin = 16'h187E; spur_en = 1'b1; cor_slow = 1'b1;
    n_mac = mac_start_cnt;
    send_byte(8'h03); send_byte(8'h20); send_byte(8'h00);
    bus.in_valid = 1'b0;
    recv_byte(b); chk("cor_b0", b, 8'h3B);
    recv_byte(b); chk("cor_b1", b, 8'h21);
    recv_byte(b); chk("cor_b2", b, 8'h18);
    recv_byte(b); chk("cor_b3", b, 8'h7E);
    chk("cor_angle", cor_angle, 16'h2000);
    chk("cor_no_mac_start", 32'(mac_start_cnt), 32'(n_mac));
    chk("cor_start_cnt", 32'(cor_start_cnt), 32'd1);
    spur_en = 1'b0; cor_slow = 1'b0;

    // ---- backpressure: out_ready low for 5 cycles in RESP
    mac_acc = 32'hDEADBEEF;
    bus.out_ready = 1'b0;
    send_byte(8'h01); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    bus.in_valid = 1'b0;
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold", {bus.out_valid, bus.in_ready, bus.out_data}, {1'b1, 1'b0, 8'hDE});
      @(negedge clk);
    end
    chk("bp_ops", {mac_a, mac_b}, 32'h11223344);
    recv_byte(b); chk("bp_b0", b, 8'hDE);
    recv_byte(b); chk("bp_b1", b, 8'hAD);
    recv_byte(b); chk("bp_b2", b, 8'hBE);
    recv_byte(b); chk("bp_b3", b, 8'hEF);

    // ---- unknown opcode, then CLR
    send_byte(8'h7F);
    bus.in_valid = 1'b0;
    chk("bad_err_set", err, 1);
    recv_byte(b); chk("bad_byte", b, 8'hEE);
    chk("bad_idle_err_sticky", {busy, err}, 2'b01);
    n_clr = mac_clr_cnt;
    send_byte(8'h02);
    bus.in_valid = 1'b0;
    chk("clr_err_cleared", err, 0);
    recv_byte(b); chk("clr_byte", b, 8'hA5);
    chk("clr_pulse_cnt", 32'(mac_clr_cnt - n_clr), 32'd1);

    // ---- ena low: offered byte is not taken
    ena = 1'b0;
    bus.in_data = 8'h01; bus.in_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("ena_hold_idle", busy, 0);
    bus.in_valid = 1'b0;
    ena = 1'b1;
    @(negedge clk);
    chk("ena_still_idle", busy, 0);

    // ---- reset after 2 MAC operand bytes
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h03);
    bus.in_valid = 1'b0;
    chk("mid_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_status", {busy, err, bus.in_ready, bus.out_valid}, 0);
    chk("mid_rst_ops", {mac_a, mac_b, cor_angle}, 0);
    chk("mid_rst_data", bus.out_data, 8'h00);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    cor_cos = 16'h7FFF; cor_sin = 16'h0001;
    n_cor = cor_start_cnt;
    send_byte(8'h03); send_byte(8'h00); send_byte(8'h00);
    bus.in_valid = 1'b0;
    recv_byte(b); chk("post_b0", b, 8'h7F);
    recv_byte(b); chk("post_b1", b, 8'hFF);
    recv_byte(b); chk("post_b2", b, 8'h00);
    recv_byte(b); chk("post_b3", b, 8'h01);
    chk("post_cor_start", 32'(cor_start_cnt - n_cor), 32'd1);
    chk("post_err", err, 0);

    // ---- MAC whose done never comes
    mac_en = 1'b0;
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h01); send_byte(8'h00); send_byte(8'h02);
    bus.in_valid = 1'b0;
    t0 = cyc;
`ifdef HERALD_SEQ_TIMEOUT_EN
    // ISSUE now; WAIT entered next edge, RESP 16 edges later, valid 1 after.
    recv_byte(b);
    chk("to_latency", 32'(t_valid - t0), 32'd18);
    chk("to_byte", b, 8'hEE);
    chk("to_err", err, 1);
    chk("to_idle", busy, 0);
`else
    repeat (300) @(negedge clk);
    chk("nto_busy", busy, 1);
    chk("nto_no_valid", bus.out_valid, 0);
`endif
    mac_en = 1'b1;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
